// File: rtl/bram_frame_reader_pkg.sv
// bram_frame_reader_pkg: shared widths and the pointer type for the frame-buffer read path
package bram_frame_reader_pkg;
   localparam int ADDR_W_DEF     = 7;
   localparam int DATA_W_DEF     = 9;
   localparam int RD_LAT_DEF     = 2;
   localparam int OBUF_DEPTH_DEF = 4;
   localparam int LAST_BIT       = DATA_W_DEF - 1;
   localparam int PTR_W          = ADDR_W_DEF + 1;
   typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/bram_frame_reader_if.sv
// bram_frame_reader_if: valid/ready byte stream toward the TX path
interface bram_frame_reader_if
   import bram_frame_reader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();
   logic [DATA_W-2:0] m_data;
   logic              m_last;
   logic              m_valid;
   logic              m_ready;
   modport master (output m_data, m_last, m_valid, input m_ready);
   modport slave  (input m_data, m_last, m_valid, output m_ready);
endinterface

// File: rtl/bram_frame_reader_obuf.sv
// bram_frame_reader_obuf: DEPTH-entry synchronous FIFO absorbing returned BRAM words
module bram_frame_reader_obuf #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               din_i,
   output logic [W-1:0]               dout_o,
   output logic [$clog2(DEPTH+1)-1:0] occ_o,
   output logic                       nempty_o
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_pop;

   assign do_pop = pop_i && cnt_q != '0;

   always_comb begin
      wr_d  = clr_i ? '0 : !push_i ? wr_q : (wr_q == IW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      rd_d  = clr_i ? '0 : !do_pop ? rd_q : (rd_q == IW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      cnt_d = clr_i ? '0 : cnt_q + CW'(push_i) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push_i && !clr_i) mem_q[wr_q] <= din_i;
      end
   end

   assign dout_o   = mem_q[rd_q];
   assign occ_o    = cnt_q;
   assign nempty_o = cnt_q != '0;

   // The parent's credit rule must keep a push from ever landing on a full buffer
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !clr_i && !do_pop && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/bram_frame_reader.sv
// bram_frame_reader: BRAM frame-buffer read controller with latency-absorbing output buffer.
// Define BRAM_FRAME_READER_FRAME_CNT_EN to build the completed-frame counter.
module bram_frame_reader
   import bram_frame_reader_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W:0]     wr_ptr_i,
   input  logic                clr_i,
   output logic [ADDR_W-1:0]   rd_addr_o,
   input  logic [DATA_W-1:0]   rd_data_i,
   output logic [ADDR_W:0]     rel_ptr_o,
   bram_frame_reader_if.master m_if,
   output logic [15:0]         frame_cnt_o,
   output logic                empty_o
);
   localparam int PW  = ADDR_W + 1;
   localparam int OCW = $clog2(OBUF_DEPTH+1);

   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, rel_ptr_q, rel_ptr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [OCW-1:0]    occ;
   logic [DATA_W-1:0] head;
   logic              issue, push, pop, nempty;

   // Credits cover both buffered words and reads still travelling through the BRAM
   assign issue = (rd_ptr_q != wr_ptr_i) && ($countones(pipe_q) + int'(occ) < OBUF_DEPTH) && !clr_i;
   assign push  = pipe_q[RD_LAT-1] && !clr_i;
   assign pop   = nempty && m_if.m_ready;

   always_comb begin
      rd_ptr_d  = clr_i ? wr_ptr_i : rd_ptr_q + PW'(issue);
      rel_ptr_d = clr_i ? wr_ptr_i : rel_ptr_q + PW'(pop);
      rd_addr_d = issue ? rd_ptr_q[ADDR_W-1:0] : rd_addr_q;
      pipe_d    = clr_i ? '0 : (pipe_q << 1) | RD_LAT'(issue);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= '0;
         rel_ptr_q <= '0;
         rd_addr_q <= '0;
         pipe_q    <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         rel_ptr_q <= rel_ptr_d;
         rd_addr_q <= rd_addr_d;
         pipe_q    <= pipe_d;
      end
   end

   bram_frame_reader_obuf #(
      .DEPTH (OBUF_DEPTH),
      .W     (DATA_W)
   ) u_obuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (clr_i),
      .push_i   (push),
      .pop_i    (pop),
      .din_i    (rd_data_i),
      .dout_o   (head),
      .occ_o    (occ),
      .nempty_o (nempty)
   );

   assign m_if.m_valid = nempty;
   assign m_if.m_data  = head[DATA_W-2:0];
   assign m_if.m_last  = head[DATA_W-1];
   assign rd_addr_o    = rd_addr_q;
   assign rel_ptr_o    = rel_ptr_q;
   assign empty_o      = (rd_ptr_q == wr_ptr_i) && pipe_q == '0 && !nempty;

`ifdef BRAM_FRAME_READER_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Survives clr so a flush does not lose the running frame total
   always_comb frame_cnt_d = (pop && m_if.m_last) ? frame_cnt_q + 16'd1 : frame_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_cnt_q <= '0;
      else        frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt_o = frame_cnt_q;
`else
   assign frame_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bram_frame_reader.sv
// tb_bram_frame_reader: directed checks of the BRAM frame reader against a behavioural BRAM
module tb_bram_frame_reader;
   import bram_frame_reader_pkg::*;

`ifdef BRAM_FRAME_READER_FRAME_CNT_EN
   localparam logic [15:0] EXP_FC = 16'd5;
`else
   localparam logic [15:0] EXP_FC = 16'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   ptr_t        wr_ptr = '0;
   logic [6:0]  rd_addr;
   logic [8:0]  rd_data;
   ptr_t        rel_ptr;
   logic [15:0] frame_cnt;
   logic        empty;
   logic [8:0]  mem [128];
   logic [8:0]  exp_q [$];
   int          errors = 0;
   int          checks = 0;

   bram_frame_reader_if m_if ();

   bram_frame_reader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_ptr_i    (wr_ptr),
      .clr_i       (clr),
      .rd_addr_o   (rd_addr),
      .rd_data_i   (rd_data),
      .rel_ptr_o   (rel_ptr),
      .m_if        (m_if),
      .frame_cnt_o (frame_cnt),
      .empty_o     (empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic do_reset;
      rst_n = 1'b0;
      wr_ptr = '0;
      clr = 1'b0;
      m_if.m_ready = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_if.m_valid); end
      checks++; if (m_if.m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_if.m_data); end
      checks++; if (m_if.m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_if.m_last); end
      checks++; if (rel_ptr !== 8'h00) begin errors++; $display("FAIL reset_rel_ptr: got %h want 00", rel_ptr); end
      checks++; if (rd_addr !== 7'h00) begin errors++; $display("FAIL reset_rd_addr: got %h want 00", rd_addr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
      checks++; if (dut.rd_ptr_q !== 8'h00) begin errors++; $display("FAIL reset_rd_ptr: got %h want 00", dut.rd_ptr_q); end
   endtask

   task automatic test_basic;
      logic [8:0] w [3];
      w[0] = 9'h011; w[1] = 9'h022; w[2] = 9'h1AB;
      do_reset();
      for (int i = 0; i < 3; i++) mem[i] = w[i];
      m_if.m_ready = 1'b1;
      wr_ptr = 8'd3;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid c%0d: got %b want 0", c, m_if.m_valid); end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({m_if.m_valid, m_if.m_last, m_if.m_data} !== {1'b1, w[i]})
            begin errors++; $display("FAIL basic_beat%0d: got v=%b %b_%h want v=1 %h", i, m_if.m_valid, m_if.m_last, m_if.m_data, w[i]); end
      end
      @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b want 0", m_if.m_valid); end
      checks++; if (rel_ptr !== 8'd3) begin errors++; $display("FAIL basic_rel_ptr: got %h want 03", rel_ptr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", empty); end
   endtask

   task automatic test_wrap;
      int n = 0, recv = 0, first = -1;
      bit saw_wrap = 0;
      logic [6:0] prev_addr = '0;
      do_reset();
      m_if.m_ready = 1'b1;
      for (int cyc = 0; cyc < 2000 && recv < 200; cyc++) begin
         for (int j = 0; j < 2; j++)
            if (n < 200 && 8'(wr_ptr - rel_ptr) < 8'd128) begin
               mem[wr_ptr[6:0]] = {n == 199, 8'(n)};
               wr_ptr = wr_ptr + 8'd1;
               n++;
            end
         if (prev_addr == 7'd127 && rd_addr == 7'd0) saw_wrap = 1;
         prev_addr = rd_addr;
         if (m_if.m_valid) begin
            if (first < 0) first = cyc;
            checks++;
            if ({m_if.m_last, m_if.m_data} !== {recv == 199, 8'(recv)})
               begin errors++; $display("FAIL wrap_beat%0d: got %b_%h want %b_%h", recv, m_if.m_last, m_if.m_data, recv == 199, 8'(recv)); end
            recv++;
         end else if (first >= 0) begin
            checks++; errors++;
            $display("FAIL wrap_gap at beat %0d: got valid=0 want 1", recv);
         end
         @(negedge clk);
      end
      checks++; if (recv != 200) begin errors++; $display("FAIL wrap_count: got %0d want 200", recv); end
      checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_addr: got no 127->0 wrap want wrap"); end
      checks++; if (rel_ptr !== 8'hC8) begin errors++; $display("FAIL wrap_rel_ptr: got %h want c8", rel_ptr); end
      checks++; if (dut.rd_ptr_q !== 8'hC8) begin errors++; $display("FAIL wrap_rd_ptr: got %h want c8", dut.rd_ptr_q); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
   endtask

   task automatic test_backpressure;
      int t;
      do_reset();
      for (int i = 0; i < 10; i++) mem[i] = {i == 9, 8'(8'h30 + i)};
      wr_ptr = 8'd10;
      repeat (8) @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({m_if.m_valid, m_if.m_data} !== {1'b1, 8'h30})
            begin errors++; $display("FAIL bp_hold c%0d: got v=%b %h want v=1 30", c, m_if.m_valid, m_if.m_data); end
         @(negedge clk);
      end
      checks++; if (dut.rd_ptr_q !== 8'd4) begin errors++; $display("FAIL bp_rd_ptr: got %h want 04", dut.rd_ptr_q); end
      checks++; if (rel_ptr !== 8'd0) begin errors++; $display("FAIL bp_rel_ptr: got %h want 00", rel_ptr); end
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         t = 0;
         while (!m_if.m_valid && t < 10) begin @(negedge clk); t++; end
         checks++;
         if ({m_if.m_valid, m_if.m_last, m_if.m_data} !== {1'b1, i == 9, 8'(8'h30 + i)})
            begin errors++; $display("FAIL bp_drain%0d: got v=%b %b_%h want v=1 %b_%h", i, m_if.m_valid, m_if.m_last, m_if.m_data, i == 9, 8'(8'h30 + i)); end
         @(negedge clk);
      end
      checks++; if (rel_ptr !== 8'd10) begin errors++; $display("FAIL bp_rel_end: got %h want 0a", rel_ptr); end
   endtask

   task automatic test_random;
      int sent = 0, recv = 0, k;
      logic [8:0] w;
      do_reset();
      for (int cyc = 0; cyc < 8000 && recv < 1000; cyc++) begin
         k = $urandom_range(0, 2);
         for (int j = 0; j < k; j++)
            if (sent < 1000 && 8'(wr_ptr - rel_ptr) < 8'd128) begin
               w = 9'($urandom_range(0, 511));
               mem[wr_ptr[6:0]] = w;
               exp_q.push_back(w);
               wr_ptr = wr_ptr + 8'd1;
               sent++;
            end
         m_if.m_ready = 1'($urandom_range(0, 1));
         if (m_if.m_valid && m_if.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rand_spurious: got %h want no beat", m_if.m_data); end
            else begin
               if ({m_if.m_last, m_if.m_data} !== exp_q[0])
                  begin errors++; $display("FAIL rand_beat%0d: got %b_%h want %h", recv, m_if.m_last, m_if.m_data, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            recv++;
         end
         checks++;
         if (8'(dut.rd_ptr_q - rel_ptr) > 8'd4)
            begin errors++; $display("FAIL rand_rel_le_rd: got rd=%h rel=%h want rd-rel<=4", dut.rd_ptr_q, rel_ptr); end
         @(negedge clk);
      end
      checks++; if (recv != 1000) begin errors++; $display("FAIL rand_count: got %0d want 1000", recv); end
      m_if.m_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL rand_dup: got valid=%b want 0", m_if.m_valid); end
   endtask

   task automatic test_clr;
      int t;
      do_reset();
      for (int i = 0; i < 40; i++) mem[i] = {1'b0, 8'(8'h80 + i)};
      wr_ptr = 8'd40;
      repeat (4) @(negedge clk);
      checks++; if ($countones(dut.pipe_q) != 2) begin errors++; $display("FAIL clr_pre_inflight: got %b want 2 set", dut.pipe_q); end
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %b want 1", m_if.m_valid); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", m_if.m_valid); end
      checks++; if (dut.rd_ptr_q !== 8'd40) begin errors++; $display("FAIL clr_rd_ptr: got %h want 28", dut.rd_ptr_q); end
      checks++; if (rel_ptr !== 8'd40) begin errors++; $display("FAIL clr_rel_ptr: got %h want 28", rel_ptr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %b want 1", empty); end
      m_if.m_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL clr_late_data c%0d: got valid=1 data=%h want valid=0", c, m_if.m_data); end
      end
      mem[40] = 9'h155;
      wr_ptr = 8'd41;
      t = 0;
      while (!m_if.m_valid && t < 10) begin @(negedge clk); t++; end
      checks++;
      if ({m_if.m_valid, m_if.m_last, m_if.m_data} !== 10'b1_1_0101_0101)
         begin errors++; $display("FAIL clr_resume: got v=%b %b_%h want v=1 1_55", m_if.m_valid, m_if.m_last, m_if.m_data); end
      @(negedge clk);
   endtask

   task automatic test_frames;
      int lens [5];
      int t;
      ptr_t p;
      lens = '{1, 2, 64, 128, 3};
      do_reset();
      m_if.m_ready = 1'b1;
      for (int f = 0; f < 5; f++) begin
         for (int j = 0; j < lens[f]; j++) begin
            p = wr_ptr + ptr_t'(j);
            mem[p[6:0]] = {j == lens[f] - 1, 8'(f * 16 + j)};
         end
         wr_ptr = wr_ptr + ptr_t'(lens[f]);
         for (int j = 0; j < lens[f]; j++) begin
            t = 0;
            while (!m_if.m_valid && t < 10) begin @(negedge clk); t++; end
            checks++;
            if ({m_if.m_valid, m_if.m_last, m_if.m_data} !== {1'b1, j == lens[f] - 1, 8'(f * 16 + j)})
               begin errors++; $display("FAIL frame%0d_beat%0d: got v=%b %b_%h want v=1 %b_%h", f, j, m_if.m_valid, m_if.m_last, m_if.m_data, j == lens[f] - 1, 8'(f * 16 + j)); end
            @(negedge clk);
         end
      end
      checks++; if (frame_cnt !== EXP_FC) begin errors++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, EXP_FC); end
      checks++; if (rel_ptr !== 8'd198) begin errors++; $display("FAIL frame_rel_ptr: got %h want c6", rel_ptr); end
   endtask

   task automatic test_async_reset;
      do_reset();
      for (int i = 0; i < 20; i++) mem[i] = 9'(9'h0A0 + i);
      m_if.m_ready = 1'b1;
      wr_ptr = 8'd20;
      repeat (6) @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b want 1", m_if.m_valid); end
      #2;
      rst_n = 1'b0;
      wr_ptr = '0;
      #1;
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", m_if.m_valid); end
      checks++; if (m_if.m_data !== 8'h00) begin errors++; $display("FAIL arst_data: got %h want 00", m_if.m_data); end
      checks++; if (rel_ptr !== 8'h00) begin errors++; $display("FAIL arst_rel_ptr: got %h want 00", rel_ptr); end
      checks++; if (dut.rd_ptr_q !== 8'h00) begin errors++; $display("FAIL arst_rd_ptr: got %h want 00", dut.rd_ptr_q); end
      checks++; if (rd_addr !== 7'h00) begin errors++; $display("FAIL arst_rd_addr: got %h want 00", rd_addr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", empty); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      m_if.m_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_random();
      test_clr();
      test_frames();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
